// File: rtl/mem_lsu_pkg.sv
// Shared decode constants for the memory-access stage.
package mem_lsu_pkg;
   localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
   localparam logic [6:0]  OPC_STORE = 7'b0100011;

   localparam logic [2:0]  F3_B  = 3'b000;
   localparam logic [2:0]  F3_H  = 3'b001;
   localparam logic [2:0]  F3_W  = 3'b010;
   localparam logic [2:0]  F3_BU = 3'b100;
   localparam logic [2:0]  F3_HU = 3'b101;

   localparam logic [31:0] INST_NOP = 32'h00000013;
endpackage

// File: rtl/mem_lsu_if.sv
// Data bus between the LSU (master) and data memory (slave).
interface mem_lsu_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane formatting: store byte enables/replication, load lane
// select with extension, and misalignment detection.
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_ext,
   output logic        misalign
);
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        sext;

   assign sext = ~funct3[2];

   // Access size comes from funct3[1:0]; bit 2 only selects zero-extension.
   always_comb begin
      be       = 4'b1111;
      wdata    = store_data;
      misalign = 1'b0;
      ld_byte  = load_data[8*addr_lo +: 8];
      ld_half  = addr_lo[1] ? load_data[31:16] : load_data[15:0];
      ld_ext   = load_data;
      case (funct3[1:0])
         2'b00: begin
            be     = 4'b0001 << addr_lo;
            wdata  = {4{store_data[7:0]}};
            ld_ext = {{24{sext & ld_byte[7]}}, ld_byte};
         end
         2'b01: begin
            be       = 4'b0011 << addr_lo;
            wdata    = {2{store_data[15:0]}};
            ld_ext   = {{16{sext & ld_half[15]}}, ld_half};
            misalign = addr_lo[0];
         end
         default: begin
            misalign = (addr_lo != 2'b00);
         end
      endcase
   end
endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: issues loads/stores on the data bus, holds the
// pipeline while an access is outstanding and forwards results to mem_wb.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] instaddr_i,
   input  logic        regs_wen_i,
   input  logic [4:0]  rd_addr_i,
   input  logic [31:0] rd_data_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] instaddr_o,
   output logic        regs_wen_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] rd_data_o,
   output logic        hold_req_o,
   mem_lsu_if.master   dbus,
   output logic        misalign_o,
   output logic        bus_err_o
);
   localparam int CW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t        state;
   logic [CW-1:0] to_cnt;
   logic [31:0]   ld_data_r;
   logic          misalign_r;
   logic          bus_err_r;

   logic [2:0]    funct3;
   logic          is_load, is_store, is_mem, misal, go, timeout_hit;
   logic [31:0]   ld_ext;
   logic [3:0]    be;
   logic [31:0]   wdata;

   assign funct3      = inst_i[14:12];
   assign is_load     = (inst_i[6:0] == OPC_LOAD);
   assign is_store    = (inst_i[6:0] == OPC_STORE);
   assign is_mem      = is_load | is_store;
   assign go          = is_mem & ~misal;
   assign timeout_hit = (to_cnt == CW'(TIMEOUT - 1));

   lsu_align u_align (
      .funct3     (funct3),
      .addr_lo    (rd_data_i[1:0]),
      .store_data (mem_wdata_i),
      .load_data  (dbus.rdata),
      .be         (be),
      .wdata      (wdata),
      .ld_ext     (ld_ext),
      .misalign   (misal)
   );

   assign dbus.we    = is_store;
   assign dbus.addr  = {rd_data_i[31:2], 2'b00};
   assign dbus.be    = be;
   assign dbus.wdata = wdata;
   assign misalign_o = misalign_r;
   assign bus_err_o  = bus_err_r;

   // Request is live in IDLE for a fresh access and throughout REQ.
   always_comb begin
      dbus.req = 1'b0;
      if (!rst) begin
         case (state)
            S_IDLE:  dbus.req = go;
            S_REQ:   dbus.req = 1'b1;
            default: dbus.req = 1'b0;
         endcase
      end
   end

   // Stores stall only until granted; loads stall until the result is back.
   always_comb begin
      hold_req_o = 1'b0;
      if (!rst) begin
         if (is_store)
            hold_req_o = dbus.req & ~dbus.gnt;
         else if (is_load)
            hold_req_o = (state == S_IDLE && go) || state == S_REQ || state == S_WAIT;
      end
   end

   // Access FSM with timeout counter, load capture and registered pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         to_cnt     <= '0;
         ld_data_r  <= '0;
         misalign_r <= 1'b0;
         bus_err_r  <= 1'b0;
      end else begin
         bus_err_r  <= 1'b0;
         misalign_r <= (state == S_IDLE) && is_mem && misal;
         case (state)
            S_IDLE: begin
               if (go) begin
                  to_cnt <= '0;
                  if (dbus.gnt) state <= is_load ? S_WAIT : S_IDLE;
                  else          state <= S_REQ;
               end
            end
            S_REQ: begin
               if (dbus.gnt) begin
                  to_cnt <= '0;
                  state  <= is_load ? S_WAIT : S_IDLE;
               end else if (timeout_hit) begin
                  state     <= S_RESP;
                  bus_err_r <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + CW'(1);
               end
            end
            S_WAIT: begin
               if (dbus.rvalid) begin
                  ld_data_r <= ld_ext;
                  state     <= S_RESP;
               end else if (timeout_hit) begin
                  state     <= S_RESP;
                  bus_err_r <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // mem_wb payload: bubble while held, load result in RESP, else pass-through.
   always_comb begin
      instaddr_o = instaddr_i;
      inst_o     = inst_i;
      rd_addr_o  = rd_addr_i;
      rd_data_o  = rd_data_i;
      regs_wen_o = regs_wen_i & ~(is_mem & misal);
      if (rst || hold_req_o) begin
         inst_o     = INST_NOP;
         rd_addr_o  = '0;
         rd_data_o  = '0;
         regs_wen_o = 1'b0;
      end else if (state == S_RESP) begin
         rd_data_o  = ld_data_r;
         regs_wen_o = regs_wen_i & ~bus_err_r;
      end
   end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, misalign, timeout, reset.
module tb_mem_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i, instaddr_i, rd_data_i, mem_wdata_i;
   logic        regs_wen_i;
   logic [4:0]  rd_addr_i;
   logic [31:0] inst_o, instaddr_o, rd_data_o;
   logic        regs_wen_o, hold_req_o, misalign_o, bus_err_o;
   logic [4:0]  rd_addr_o;
   int          total = 0;
   int          bad = 0;

   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] ADDI = 32'h00500093;

   mem_lsu_if dbus ();

   mem_lsu #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .inst_i(inst_i), .instaddr_i(instaddr_i), .regs_wen_i(regs_wen_i),
      .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .mem_wdata_i(mem_wdata_i),
      .inst_o(inst_o), .instaddr_o(instaddr_o), .regs_wen_o(regs_wen_o),
      .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .hold_req_o(hold_req_o),
      .dbus(dbus.master), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
      return {12'h000, 5'd1, f3, 5'd5, op};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [31:0] inst, input logic [31:0] addr,
                         input logic wen, input logic [31:0] wd);
      inst_i = inst; rd_data_i = addr; regs_wen_i = wen; mem_wdata_i = wd;
      rd_addr_i = 5'd5; instaddr_i = 32'h40;
   endtask

   // Best-case load: gnt in cycle 0, rvalid in cycle 1, result in cycle 2.
   task automatic do_load(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
      set_op(inst, addr, 1'b1, 32'h0);
      dbus.gnt = 1'b1; dbus.rvalid = 1'b0; #2;
      chk({tag, "_c0_req"},  dbus.req, 1);
      chk({tag, "_c0_addr"}, dbus.addr, {addr[31:2], 2'b00});
      chk({tag, "_c0_hold"}, hold_req_o, 1);
      chk({tag, "_c0_inst"}, inst_o, NOP);
      chk({tag, "_c0_wen"},  regs_wen_o, 0);
      chk({tag, "_c0_iaddr"}, instaddr_o, 32'h40);
      step();
      dbus.gnt = 1'b0; dbus.rvalid = 1'b1; dbus.rdata = rdata; #2;
      chk({tag, "_c1_req"},  dbus.req, 0);
      chk({tag, "_c1_hold"}, hold_req_o, 1);
      chk({tag, "_c1_data"}, rd_data_o, 0);
      step();
      dbus.rvalid = 1'b0; #2;
      chk({tag, "_c2_hold"}, hold_req_o, 0);
      chk({tag, "_c2_data"}, rd_data_o, exp);
      chk({tag, "_c2_wen"},  regs_wen_o, 1);
      chk({tag, "_c2_inst"}, inst_o, inst);
      step();
      set_op(ADDI, 32'h5, 1'b1, 32'h0); #2;
      chk({tag, "_idle_req"}, dbus.req, 0);
      chk({tag, "_idle_data"}, rd_data_o, 32'h5);
      step();
   endtask

   initial begin
      rst = 1'b1;
      set_op(mk(3'b010, 7'b0000011), 32'h100, 1'b1, 32'h0);
      dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = 32'h0;
      step(); #2;
      chk("rst_req",  dbus.req, 0);
      chk("rst_hold", hold_req_o, 0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_wen",  regs_wen_o, 0);
      chk("rst_mis",  misalign_o, 0);
      chk("rst_err",  bus_err_o, 0);
      set_op(ADDI, 32'h5, 1'b1, 32'h0);
      step();
      rst = 1'b0; #2;
      chk("pass_inst", inst_o, ADDI);
      chk("pass_data", rd_data_o, 32'h5);
      chk("pass_wen",  regs_wen_o, 1);
      chk("pass_req",  dbus.req, 0);
      step();

      do_load("lw",  mk(3'b010, 7'b0000011), 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
      do_load("lb",  mk(3'b000, 7'b0000011), 32'h103, 32'h80FFFF7F, 32'hFFFFFF80);
      do_load("lbu", mk(3'b100, 7'b0000011), 32'h103, 32'h80FFFF7F, 32'h00000080);
      do_load("lh",  mk(3'b001, 7'b0000011), 32'h102, 32'h80FFFF7F, 32'hFFFF80FF);
      do_load("lhu", mk(3'b101, 7'b0000011), 32'h100, 32'h80FFFF7F, 32'h0000FF7F);

      // sh with gnt delayed 3 cycles
      set_op(mk(3'b001, 7'b0100011), 32'h202, 1'b0, 32'h1234ABCD);
      dbus.gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("sh_req",   dbus.req, 1);
         chk("sh_hold",  hold_req_o, 1);
         chk("sh_we",    dbus.we, 1);
         chk("sh_addr",  dbus.addr, 32'h200);
         chk("sh_be",    {28'h0, dbus.be}, 32'hC);
         chk("sh_wdata", dbus.wdata, 32'hABCDABCD);
         chk("sh_bub",   inst_o, NOP);
         step();
      end
      dbus.gnt = 1'b1; #2;
      chk("sh_gnt_req",  dbus.req, 1);
      chk("sh_gnt_hold", hold_req_o, 0);
      step();
      dbus.gnt = 1'b0;
      set_op(ADDI, 32'h5, 1'b1, 32'h0); #2;
      chk("sh_after_req", dbus.req, 0);
      step();

      // sw granted immediately: no stall
      set_op(mk(3'b010, 7'b0100011), 32'h300, 1'b0, 32'hCAFEF00D);
      dbus.gnt = 1'b1; #2;
      chk("sw_req",   dbus.req, 1);
      chk("sw_hold",  hold_req_o, 0);
      chk("sw_be",    {28'h0, dbus.be}, 32'hF);
      chk("sw_wdata", dbus.wdata, 32'hCAFEF00D);
      step();
      dbus.gnt = 1'b0;
      set_op(mk(3'b000, 7'b0100011), 32'h301, 1'b0, 32'h000000A5); #2;
      chk("sb_be",    {28'h0, dbus.be}, 32'h2);
      chk("sb_wdata", dbus.wdata, 32'hA5A5A5A5);
      dbus.gnt = 1'b1;
      step();
      dbus.gnt = 1'b0;

      // misaligned lw
      set_op(mk(3'b010, 7'b0000011), 32'h101, 1'b1, 32'h0); #2;
      chk("mis_req",  dbus.req, 0);
      chk("mis_hold", hold_req_o, 0);
      chk("mis_wen",  regs_wen_o, 0);
      chk("mis_inst", inst_o, mk(3'b010, 7'b0000011));
      chk("mis_pulse0", misalign_o, 0);
      step();
      set_op(ADDI, 32'h5, 1'b1, 32'h0); #2;
      chk("mis_pulse1", misalign_o, 1);
      step(); #2;
      chk("mis_pulse2", misalign_o, 0);
      step();

      // lw timeout: gnt, then no rvalid for 16 WAIT cycles
      set_op(mk(3'b010, 7'b0000011), 32'h100, 1'b1, 32'h0);
      dbus.gnt = 1'b1; #2;
      chk("to_c0_hold", hold_req_o, 1);
      step();
      dbus.gnt = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #2;
         chk("to_wait_hold", hold_req_o, 1);
         chk("to_wait_err",  bus_err_o, 0);
         chk("to_wait_req",  dbus.req, 0);
         step();
      end
      dbus.rvalid = 1'b1; dbus.rdata = 32'h55555555; #2;
      chk("to_resp_err",  bus_err_o, 1);
      chk("to_resp_wen",  regs_wen_o, 0);
      chk("to_resp_hold", hold_req_o, 0);
      chk("to_resp_inst", inst_o, mk(3'b010, 7'b0000011));
      step();
      set_op(ADDI, 32'h5, 1'b1, 32'h0); #2;
      chk("to_after_err",  bus_err_o, 0);
      chk("to_after_req",  dbus.req, 0);
      chk("to_after_data", rd_data_o, 32'h5);
      step();
      dbus.rvalid = 1'b0;

      // reset during WAIT, rvalid arrives while in reset
      set_op(mk(3'b010, 7'b0000011), 32'h100, 1'b1, 32'h0);
      dbus.gnt = 1'b1; #2;
      chk("rw_c0_req", dbus.req, 1);
      step();
      dbus.gnt = 1'b0; rst = 1'b1; #2;
      chk("rw_rst_req",  dbus.req, 0);
      chk("rw_rst_hold", hold_req_o, 0);
      chk("rw_rst_inst", inst_o, NOP);
      step();
      dbus.rvalid = 1'b1; dbus.rdata = 32'h12345678; #2;
      chk("rw_rv_wen",  regs_wen_o, 0);
      chk("rw_rv_hold", hold_req_o, 0);
      step();
      rst = 1'b0; dbus.rvalid = 1'b0;
      set_op(ADDI, 32'h5, 1'b1, 32'h0); #2;
      chk("rw_idle_req",  dbus.req, 0);
      chk("rw_idle_hold", hold_req_o, 0);
      chk("rw_idle_data", rd_data_o, 32'h5);
      chk("rw_idle_err",  bus_err_o, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
